// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester and memory-side signal bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              x_req;
    logic              x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic              x_gnt;
    logic              x_rvalid;
    logic [DATA_W-1:0] x_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Master side is the environment: the three requesters plus the memory.
    modport master (
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output x_req, x_we, x_addr, x_wdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  x_req, x_we, x_addr, x_wdata,
        output x_gnt, x_rvalid, x_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Three-way aged fixed-priority arbiter onto one sync-read memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] c_limit    = 4'(STARVE_LIMIT);
    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_d    = 2'd1;
    localparam logic [1:0] c_own_i    = 2'd2;
    localparam logic [1:0] c_own_x    = 2'd3;

    logic [3:0] age_i_q, age_i_d;
    logic [3:0] age_x_q, age_x_d;
    logic [1:0] rd_owner_q, rd_owner_d;

    logic w_prom_i, w_prom_x;
    logic w_gnt_d, w_gnt_i, w_gnt_x;

    assign w_prom_i = (age_i_q == c_limit);
    assign w_prom_x = (age_x_q == c_limit);

    // Order: promoted i, promoted x, then base d > i > x.
    always_comb begin
        w_gnt_d = 1'b0;
        w_gnt_i = 1'b0;
        w_gnt_x = 1'b0;
        if (!rst) begin
            if (bus.i_req && w_prom_i)      w_gnt_i = 1'b1;
            else if (bus.x_req && w_prom_x) w_gnt_x = 1'b1;
            else if (bus.d_req)             w_gnt_d = 1'b1;
            else if (bus.i_req)             w_gnt_i = 1'b1;
            else if (bus.x_req)             w_gnt_x = 1'b1;
        end
    end

    assign bus.d_gnt = w_gnt_d;
    assign bus.i_gnt = w_gnt_i;
    assign bus.x_gnt = w_gnt_x;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        rd_owner_d    = c_own_none;
        if (w_gnt_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_re    = !bus.d_we;
            bus.mem_we    = bus.d_we;
            bus.mem_wdata = bus.d_wdata;
            rd_owner_d    = bus.d_we ? c_own_none : c_own_d;
        end else if (w_gnt_i) begin
            bus.mem_addr  = bus.i_addr;
            bus.mem_re    = 1'b1;
            rd_owner_d    = c_own_i;
        end else if (w_gnt_x) begin
            bus.mem_addr  = bus.x_addr;
            bus.mem_re    = !bus.x_we;
            bus.mem_we    = bus.x_we;
            bus.mem_wdata = bus.x_wdata;
            rd_owner_d    = bus.x_we ? c_own_none : c_own_x;
        end
    end

    always_comb begin
        age_i_d = age_i_q;
        age_x_d = age_x_q;
        if (!bus.i_req || w_gnt_i)  age_i_d = 4'd0;
        else if (age_i_q < c_limit) age_i_d = age_i_q + 4'd1;
        if (!bus.x_req || w_gnt_x)  age_x_d = 4'd0;
        else if (age_x_q < c_limit) age_x_d = age_x_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_i_q    <= 4'd0;
            age_x_q    <= 4'd0;
            rd_owner_q <= c_own_none;
        end else begin
            age_i_q    <= age_i_d;
            age_x_q    <= age_x_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Reset masks a read already in flight so no stale data is returned.
    assign bus.d_rvalid = !rst && (rd_owner_q == c_own_d);
    assign bus.i_rvalid = !rst && (rd_owner_q == c_own_i);
    assign bus.x_rvalid = !rst && (rd_owner_q == c_own_x);

    assign bus.d_rdata = bus.d_rvalid ? bus.mem_rdata : '0;
    assign bus.i_rdata = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.x_rdata = bus.x_rvalid ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [15:0] mem [0:511];

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory; reset reloads the known contents.
    always @(posedge clk) begin
        if (rst) begin
            mem[9'h002] <= 16'hD002;
            mem[9'h010] <= 16'hFF10;
            mem[9'h011] <= 16'h1111;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
        end
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.x_req = 1'b0; bus.x_we = 1'b0; bus.x_addr = '0; bus.x_wdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.mem_rdata = '0;
        idle();
        rst = 1'b1;
        cyc(); cyc();

        // Requests during reset are never granted.
        bus.d_req = 1'b1; bus.i_req = 1'b1; bus.x_req = 1'b1;
        settle();
        check_eq("rst_gnt", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b000);
        check_eq("rst_strobes", {bus.mem_re, bus.mem_we}, 2'b00);
        check_eq("rst_rvalid", {bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}, 3'b000);
        check_eq("rst_rdata", bus.i_rdata, 16'h0);
        cyc();
        check_eq("rst_age", {dut.age_i_q, dut.age_x_q}, 8'h00);
        idle();
        rst = 1'b0;
        cyc();

        // Single fetch read
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        settle();
        check_eq("rd_gnt", {bus.d_gnt, bus.i_gnt, bus.x_gnt, bus.mem_re}, 4'b0101);
        check_eq("rd_addr", bus.mem_addr, 16'h0010);
        cyc();
        idle();
        settle();
        check_eq("rd_rvalid", {bus.i_rvalid, bus.mem_re}, 2'b10);
        check_eq("rd_rdata", bus.i_rdata, 16'hFF10);
        cyc();
        settle();
        check_eq("rd_done", bus.i_rvalid, 1'b0);

        // Priority with all three requesting
        bus.d_req = 1'b1; bus.d_addr = 16'h0002;
        bus.i_req = 1'b1; bus.i_addr = 16'h0011;
        bus.x_req = 1'b1; bus.x_we = 1'b1; bus.x_addr = 16'h0040; bus.x_wdata = 16'h00AA;
        settle();
        check_eq("pri_d", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b100);
        cyc();
        bus.d_req = 1'b0;
        settle();
        check_eq("pri_i", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b010);
        check_eq("pri_d_rdata", {bus.d_rvalid, bus.d_rdata}, {1'b1, 16'hD002});
        cyc();
        bus.i_req = 1'b0;
        settle();
        check_eq("pri_x", {bus.d_gnt, bus.i_gnt, bus.x_gnt, bus.mem_we}, 4'b0011);
        check_eq("pri_x_wdata", bus.mem_wdata, 16'h00AA);
        check_eq("pri_i_rdata", {bus.i_rvalid, bus.i_rdata}, {1'b1, 16'h1111});
        cyc();
        bus.x_we = 1'b0;
        settle();
        check_eq("wr_no_rvalid", bus.x_rvalid, 1'b0);
        check_eq("x_rd_gnt", bus.x_gnt, 1'b1);
        cyc();
        idle();
        settle();
        check_eq("x_rd_data", {bus.x_rvalid, bus.x_rdata}, {1'b1, 16'h00AA});
        cyc();

        // Starvation: d holds the port, i must get in on the 5th cycle
        bus.d_req = 1'b1; bus.d_addr = 16'h0002;
        bus.i_req = 1'b1; bus.i_addr = 16'h0011;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq($sformatf("starve_deny%0d", k), {bus.d_gnt, bus.i_gnt}, 2'b10);
            cyc();
        end
        settle();
        check_eq("starve_gnt", {bus.d_gnt, bus.i_gnt}, 2'b01);
        cyc();
        settle();
        check_eq("starve_age_clr", dut.age_i_q, 4'd0);
        check_eq("starve_rdata", {bus.i_rvalid, bus.i_rdata}, {1'b1, 16'h1111});
        check_eq("starve_d_back", {bus.d_gnt, bus.i_gnt}, 2'b10);
        // Dropping req clears the age
        cyc();
        bus.i_req = 1'b0;
        cyc();
        settle();
        check_eq("drop_age_clr", dut.age_i_q, 4'd0);
        idle();
        cyc();

        // Back-to-back write then read of the same address
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
        settle();
        check_eq("b2b_wr", {bus.d_gnt, bus.mem_we, bus.mem_re}, 3'b110);
        cyc();
        bus.d_we = 1'b0;
        settle();
        check_eq("b2b_rd", {bus.d_gnt, bus.mem_re, bus.d_rvalid}, 3'b110);
        cyc();
        idle();
        settle();
        check_eq("b2b_data", {bus.d_rvalid, bus.d_rdata}, {1'b1, 16'h1234});
        cyc();

        // Reset arriving the cycle after a granted read
        bus.x_req = 1'b1; bus.x_addr = 16'h0040;
        settle();
        check_eq("mr_gnt", bus.x_gnt, 1'b1);
        cyc();
        rst = 1'b1;
        settle();
        check_eq("mr_rvalid1", {bus.x_rvalid, bus.x_rdata}, {1'b0, 16'h0});
        check_eq("mr_nogrant", {bus.d_gnt, bus.i_gnt, bus.x_gnt, bus.mem_re, bus.mem_we}, 5'b0);
        cyc();
        settle();
        check_eq("mr_rvalid2", bus.x_rvalid, 1'b0);
        rst = 1'b0;
        settle();
        check_eq("mr_regrant", bus.x_gnt, 1'b1);
        cyc();
        idle();
        settle();
        check_eq("mr_data", {bus.x_rvalid, bus.x_rdata}, {1'b1, 16'h00AA});
        cyc();

        // Both i and x promoted
        bus.d_req = 1'b1; bus.d_addr = 16'h0002;
        bus.i_req = 1'b1; bus.i_addr = 16'h0011;
        bus.x_req = 1'b1; bus.x_addr = 16'h0010;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq($sformatf("both_d%0d", k), {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b100);
            cyc();
        end
        settle();
        check_eq("both_i", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b010);
        cyc();
        settle();
        check_eq("both_x", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b001);
        check_eq("both_i_rdata", bus.i_rdata, 16'h1111);
        cyc();
        settle();
        check_eq("both_d_after", {bus.d_gnt, bus.i_gnt, bus.x_gnt}, 3'b100);
        check_eq("both_x_rdata", {bus.x_rvalid, bus.x_rdata}, {1'b1, 16'hFF10});
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, synchronous-read 16-bit memory between three requesters: CPU data access (`d_`), CPU instruction fetch (`i_`) and the I/O/DMA engine (`x_`). It replaces the separate instruction and data memory buses with one arbitrated port. Each requester gets a grant/read-valid handshake. Fixed priority is bounded by per-requester aging counters, so no requester starves.

## Interface
- `ADDR_W`, 16, address width of every port.
- `DATA_W`, 16, data width of every port.
- `STARVE_LIMIT`, 4, consecutive denied cycles after which `i` or `x` is promoted above `d` (1..15).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_req`  in  1  data requester wants the port this cycle.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data request address.
- `d_wdata`  in  DATA_W  data write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data read data valid.
- `d_rdata`  out  DATA_W  data read data.
- `i_req`, `i_addr`, `i_gnt`, `i_rvalid`, `i_rdata`  same meaning for fetch; fetch is read-only.
- `x_req`, `x_we`, `x_addr`, `x_wdata`, `x_gnt`, `x_rvalid`, `x_rdata`  same meaning for I/O/DMA.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_re`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; registered, valid one cycle after `mem_re`.

## Operation
- At most one grant per cycle.
- `*_gnt` is combinational from the current `*_req` and the aging state.
- Memory strobes, address and write data are driven combinationally from the granted requester.
- With no grant: `mem_re` = `mem_we` = 0; `mem_addr` and `mem_wdata` = 0.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until `gnt`; the arbiter does not latch request fields.
- Base priority: `d` > `i` > `x`.
- Aging counters `age_i` and `age_x`, 4-bit:
  - increment on each cycle the requester has `req` = 1 and `gnt` = 0;
  - saturate at `STARVE_LIMIT`;
  - clear on grant, or on any cycle its `req` = 0.
- Promotion: `age_i` == `STARVE_LIMIT` puts `i` above `d`; `age_x` == `STARVE_LIMIT` puts `x` above `d`. If both are promoted, `i` wins.
- Read-owner register `rd_owner`, one of {NONE, D, I, X}:
  - loads the granted requester on a granted read;
  - loads NONE on a granted write or on no grant.
- Return path:
  - `*_rvalid` = (`rd_owner` == that requester).
  - `*_rdata` = `mem_rdata` when its `rvalid` is 1, else 0.
- Writes produce no `rvalid`.

## Timing
- Request accepted in cycle N (`gnt` = 1): the memory samples the address and strobes at the rising edge ending N.
- Read data returns at `*_rvalid` in cycle N+1. Latency is 1 cycle and fixed.
- The same requester may be granted every cycle; a read issued in N+1 overlaps the N+1 data return. Throughput is 1 access per cycle.
- Write in N followed by a read of the same address in N+1 returns the new data.
- Reset values, applied at the first edge with `rst` = 1:
  - `rd_owner` = NONE, `age_i` = 0, `age_x` = 0;
  - all `*_rvalid` = 0, all `*_rdata` = 0.
- While `rst` = 1: all `*_gnt` = 0 and `mem_re` = `mem_we` = 0 combinationally.
- Reset mid-operation: a read granted in cycle N with `rst` asserted in N+1 produces no `rvalid` in N+1 (reset dominates). Outstanding requests are simply not granted until `rst` drops.
- Simultaneous events:
  - three requests, no aging: `d` granted;
  - `i` and `x` both promoted: `i` granted, `x` keeps saturated age and wins next cycle unless `i` remains promoted.
- Dropping `req` before `gnt` is legal: no access occurs and that requester's age clears.
- Fetch requests ignore any write intent; the fetch port has no `we`.

## Test plan
- Single read: preload mem[0x0010] = 0xFF10; `i_req` with `i_addr` = 0x0010 in cycle N -> `i_gnt` = 1 in N, `i_rvalid` = 1 and `i_rdata` = 0xFF10 in N+1, `mem_re` = 1 only in N.
- Priority: `d_req` read 0x0002, `i_req` 0x0011 and `x_req` write 0x0040 = 0x00AA all in the same cycle -> `d_gnt` only; then with `d_req` dropped -> `i`, then `x`; mem[0x0040] = 0x00AA afterwards.
- Starvation, `STARVE_LIMIT` = 4: `d_req` held continuously with `i_req` held -> `i` denied 4 cycles, `i_gnt` = 1 on the 5th cycle, `d_gnt` = 0 that cycle, `age_i` back to 0.
- Back-to-back: `d` writes 0x1234 to 0x0100 in N and reads 0x0100 in N+1 -> `d_rvalid` = 1 with 0x1234 in N+2; no `d_rvalid` in N+1.
- Reset mid-read: `x` read granted in N, `rst` = 1 in N+1 -> `x_rvalid` = 0 in N+1 and N+2, all grants 0 while `rst` = 1.
- Both promoted: hold `d`, `i` and `x` until ages saturate -> `i` granted, then `x` on the following cycle, ahead of `d`.
